// File: rtl/gpioemu_bus_master.sv
// gpioemu_bus_master: host-side initiator for the gpioemu register bus.
// Turns a valid/ready byte stream into DATA/PUT writes, then GET, STATE
// polling, RESULT read and an automatic CLR, returning the 32-bit result.
module gpioemu_bus_master #(
    parameter logic [15:0] BASE_ADDR  = 16'h0640,
    parameter int unsigned POLL_GAP   = 4,
    parameter int unsigned POLL_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    input  logic        byte_last,
    output logic        byte_ready,
    input  logic        get_req,
    input  logic        clr_req,
    output logic [15:0] saddress,
    output logic        srd,
    output logic        swr,
    output logic [31:0] sdata_wr,
    input  logic [31:0] sdata_rd,
    output logic [31:0] res_data,
    output logic        res_valid,
    output logic        res_err,
    output logic        res_timeout,
    output logic        busy
);

    localparam logic [15:0] ADDR_DATA   = BASE_ADDR;
    localparam logic [15:0] ADDR_STATE  = BASE_ADDR + 16'd8;
    localparam logic [15:0] ADDR_RESULT = BASE_ADDR + 16'd16;
    localparam logic [15:0] ADDR_CTRL   = BASE_ADDR + 16'd24;

    localparam logic [31:0] CMD_PUT = 32'd1;
    localparam logic [31:0] CMD_GET = 32'd2;
    localparam logic [31:0] CMD_CLR = 32'd3;

    localparam logic [31:0] ST_READY = 32'd3;
    localparam logic [31:0] ST_ERROR = 32'd4;

    localparam logic [7:0]  GAP_LAST  = (POLL_GAP == 0) ? 8'd0 : 8'(POLL_GAP - 1);
    localparam logic [15:0] POLL_LAST = 16'(POLL_LIMIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_PUT,
        WR_GET,
        POLL,
        POLL_WAIT,
        RD_RES,
        WR_CLR
    } state_t;

    state_t      state;
    logic [1:0]  phase;        // 0 = A0 (setup), 1 = A1 (strobe), 2 = A2 (hold)
    logic [7:0]  byte_reg;
    logic        last_reg;
    logic [7:0]  byte_count;
    logic [15:0] poll_count;
    logic [7:0]  gap_count;
    logic        clr_pending;

    // Handshake and status are pure decodes of the state register.
    assign byte_ready = (state == IDLE) && !reset;
    assign busy       = (state != IDLE);

    // Sequencer: every bus state runs A0/A1/A2; address and write data are
    // loaded on the edge that enters the state so A0 already presents them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            phase       <= 2'd0;
            byte_reg    <= '0;
            last_reg    <= 1'b0;
            byte_count  <= '0;
            poll_count  <= '0;
            gap_count   <= '0;
            clr_pending <= 1'b0;
            saddress    <= '0;
            sdata_wr    <= '0;
            srd         <= 1'b0;
            swr         <= 1'b0;
            res_data    <= '0;
            res_valid   <= 1'b0;
            res_err     <= 1'b0;
            res_timeout <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            // Any entry into WR_CLR below clears this again, which drops a
            // request that arrives while already headed to CLR.
            if (clr_req && state != IDLE && state != WR_CLR)
                clr_pending <= 1'b1;

            if (state == IDLE) begin
                phase <= 2'd0;
                if (byte_valid) begin
                    byte_reg <= byte_data;
                    last_reg <= byte_last;
                    saddress <= ADDR_DATA;
                    sdata_wr <= {24'b0, byte_data};
                    state    <= WR_DATA;
                end else if (get_req) begin
                    saddress <= ADDR_CTRL;
                    sdata_wr <= CMD_GET;
                    state    <= WR_GET;
                end else if (clr_req) begin
                    saddress <= ADDR_CTRL;
                    sdata_wr <= CMD_CLR;
                    state    <= WR_CLR;
                end
            end else if (state == POLL_WAIT) begin
                if (gap_count == GAP_LAST) begin
                    phase <= 2'd0;
                    state <= POLL;
                end else begin
                    gap_count <= gap_count + 8'd1;
                end
            end else if (phase == 2'd0) begin
                if (state == POLL || state == RD_RES) srd <= 1'b1;
                else                                   swr <= 1'b1;
                phase <= 2'd1;
            end else if (phase == 2'd1) begin
                srd   <= 1'b0;
                swr   <= 1'b0;
                phase <= 2'd2;
            end else begin
                phase <= 2'd0;
                case (state)
                    WR_DATA: begin
                        saddress <= ADDR_CTRL;
                        sdata_wr <= CMD_PUT;
                        state    <= WR_PUT;
                    end
                    WR_PUT: begin
                        if (byte_count != 8'hFF) byte_count <= byte_count + 8'd1;
                        saddress <= ADDR_CTRL;
                        if (last_reg) begin
                            sdata_wr <= CMD_GET;
                            state    <= WR_GET;
                        end else if (clr_pending || clr_req) begin
                            sdata_wr    <= CMD_CLR;
                            clr_pending <= 1'b0;
                            state       <= WR_CLR;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    WR_GET: begin
                        poll_count <= '0;
                        saddress   <= ADDR_STATE;
                        sdata_wr   <= '0;
                        state      <= POLL;
                    end
                    POLL: begin
                        poll_count <= poll_count + 16'd1;
                        if (sdata_rd == ST_READY) begin
                            saddress <= ADDR_RESULT;
                            state    <= RD_RES;
                        end else if (sdata_rd == ST_ERROR || poll_count == POLL_LAST) begin
                            res_data    <= '0;
                            res_err     <= 1'b1;
                            res_timeout <= (sdata_rd != ST_ERROR);
                            res_valid   <= 1'b1;
                            saddress    <= ADDR_CTRL;
                            sdata_wr    <= CMD_CLR;
                            clr_pending <= 1'b0;
                            state       <= WR_CLR;
                        end else if (POLL_GAP == 0) begin
                            state <= POLL;
                        end else begin
                            gap_count <= '0;
                            state     <= POLL_WAIT;
                        end
                    end
                    RD_RES: begin
                        res_data    <= sdata_rd;
                        res_err     <= 1'b0;
                        res_timeout <= 1'b0;
                        res_valid   <= 1'b1;
                        saddress    <= ADDR_CTRL;
                        sdata_wr    <= CMD_CLR;
                        clr_pending <= 1'b0;
                        state       <= WR_CLR;
                    end
                    WR_CLR: begin
                        byte_count <= '0;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
